lcd_nibble_writer: RTL and testbench
====================================

Name: lcd_nibble_writer

Overview:
- Byte-level HD44780 bus driver that services the LCD sequencer's write handshake (data, cmd_data, ena_write in; done_write out).
- Splits each accepted byte into two 4-bit transfers on the LCD pins: high nibble first, then low nibble.
- Generates E pulse timing and waits the controller execution time before acknowledging.
- Performs a power-up wait after reset and sits between the sequencer and the LCD pins.

Parameters:
- POWERUP_US, 20000, cycles (us at 1 MHz) to hold off after reset before any LCD access
- T_SETUP, 1, cycles RS/D valid before E rises
- T_EN, 1, cycles E held high
- T_HOLD, 1, cycles RS/D held after E falls
- T_EXEC, 40, execution wait after the low nibble for normal commands and data
- T_EXEC_LONG, 1640, execution wait after the low nibble for clear (0x01) and home (0x02/0x03) commands
- CNT_W, 16, timer width; must hold max(POWERUP_US, T_EXEC_LONG)

Ports:
- clk_1MHz  in  1  system clock, 1 us period
- rst_n  in  1  asynchronous active-low reset
- data  in  8  byte to write; sampled on the acceptance edge only
- cmd_data  in  1  0 = command (RS=0), 1 = data (RS=1); sampled with data
- ena_write  in  1  write request, one-cycle pulse from the sequencer
- done_write  out  1  one-cycle pulse when the byte has been written and executed
- busy  out  1  high whenever a new request would not be accepted immediately
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD R/W, constant 0 (write only)
- lcd_e  out  1  LCD enable strobe
- lcd_d  out  4  LCD data bus D7..D4

Behaviour:
- Clock and reset:
  - One clock, clk_1MHz.
  - Reset is asynchronous, active-low on rst_n.
  - All outputs are registered.
- Reset values:
  - done_write=0, busy=1, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_d=0.
  - Timer=0, pending=0, state=POWERUP.
- States: POWERUP, IDLE, HI_SETUP, HI_EN, HI_HOLD, LO_SETUP, LO_EN, LO_HOLD, EXEC_WAIT, DONE.
- POWERUP:
  - Lasts POWERUP_US cycles.
  - Then go to IDLE if no request is pending, or to HI_SETUP if one is pending.
- IDLE:
  - busy=0.
  - ena_write=1 at an edge accepts the request: latch data and cmd_data, go to HI_SETUP.
  - busy rises on that same edge.
- HI_SETUP:
  - lcd_rs=latched cmd_data, lcd_d=data[7:4], lcd_e=0.
  - Lasts T_SETUP cycles.
- HI_EN: lcd_e=1 for T_EN cycles, bus unchanged.
- HI_HOLD: lcd_e=0 for T_HOLD cycles, bus unchanged.
- LO_SETUP / LO_EN / LO_HOLD: same sequence with lcd_d=data[3:0].
- EXEC_WAIT:
  - Lasts T_EXEC_LONG cycles if the latched cmd_data=0 and data[7:2]=0 (codes 0x00–0x03).
  - Otherwise lasts T_EXEC cycles.
  - lcd_e=0 throughout; lcd_rs and lcd_d keep their last values.
- DONE:
  - done_write=1 for exactly one cycle, then go to IDLE.
  - busy falls on the IDLE entry edge.
- Latency: done_write is high in cycle N after the acceptance edge, where N = 2*(T_SETUP+T_EN+T_HOLD) + T_EXEC + 1.
  - Defaults: N=47 for normal writes, N=1647 for long commands.
- ena_write during POWERUP:
  - Sets pending and latches data and cmd_data.
  - Further pulses while pending=1 are ignored (first request wins).
  - pending clears on entry to HI_SETUP.
- ena_write in any state other than IDLE or POWERUP:
  - Ignored: no latch, no queueing, in-flight transfer unaffected.
- ena_write in IDLE on the same edge that DONE exits: DONE always returns to IDLE first, so the request is accepted on the next edge at which it is high. The sequencer pulse never coincides with DONE.
- Reset mid-operation:
  - Immediate return to reset values; lcd_e drops asynchronously.
  - Full POWERUP wait is re-run.
  - No done_write is issued for the aborted byte.
- Timer:
  - Single down-counter, loaded with (duration-1) on state entry.
  - The state advances when the counter reads 0.
  - Parameters of 0 are illegal and treated as 1.

Decomposition:
- Package lcd_pkg:
  - State encoding.
  - Default timing constants (POWERUP_US, T_SETUP, T_EN, T_HOLD, T_EXEC, T_EXEC_LONG).
  - Command codes: CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_FUNC_4BIT=8'h28, CMD_ENTRY=8'h06, CMD_DISP_ON=8'h0C, CMD_LINE1=8'h80, CMD_LINE2=8'hC0.
- Sub-module lcd_tick_timer:
  - Loadable CNT_W down-counter with load and zero flag.
  - Shared with lcd_display's delay logic in later cleanup.

Test Plan:
1. Reset, hold ena_write=0 -> busy=1 for 20000 cycles, then busy=0; lcd_e never rises; lcd_rw=0 throughout.
2. After power-up, send data=8'h41, cmd_data=1 -> lcd_rs=1 with lcd_d=4'h4, E high exactly cycle 2, then lcd_d=4'h1, E high exactly cycle 5; done_write single pulse at cycle 47.
3. Send data=8'h01, cmd_data=0 -> lcd_rs=0, nibbles 0x0 then 0x1; done_write at cycle 1647. Repeat with 8'h01, cmd_data=1 -> done_write at cycle 47 (data write is never long).
4. Pulse ena_write with 8'h28 at cycle 100 of POWERUP, then 8'h0C at cycle 200 -> after power-up only 0x2/0x8 appear on the bus, with one done_write; 0x0C is never driven.
5. Pulse ena_write with 8'h80 during EXEC_WAIT of 8'h06 -> ignored; exactly one done_write; bus shows only 0x0/0x6.
6. Assert rst_n=0 while in LO_EN -> lcd_e=0 immediately, done_write never pulses, busy=1; POWERUP restarts from a full 20000-cycle count.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encoding, default timing and command codes for the LCD bus driver
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_HI_SETUP,
    ST_HI_EN,
    ST_HI_HOLD,
    ST_LO_SETUP,
    ST_LO_EN,
    ST_LO_HOLD,
    ST_EXEC_WAIT,
    ST_DONE
  } lcd_state_t;

  localparam int POWERUP_US  = 20000;
  localparam int T_SETUP     = 1;
  localparam int T_EN        = 1;
  localparam int T_HOLD      = 1;
  localparam int T_EXEC      = 40;
  localparam int T_EXEC_LONG = 1640;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_LINE1     = 8'h80;
  localparam logic [7:0] CMD_LINE2     = 8'hC0;

  // Timer reload for a duration of n cycles; a zero duration behaves as one cycle.
  function automatic int tick_count(input int n);
    return (n < 1) ? 0 : n - 1;
  endfunction

endpackage

// File: rtl/lcd_tick_timer.sv
// rtl/lcd_tick_timer.sv - loadable down-counter with zero flag
module lcd_tick_timer #(
  parameter int              CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_1MHz,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - byte-to-nibble HD44780 write driver with E timing and execution wait
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int POWERUP_US  = lcd_pkg::POWERUP_US,
  parameter int T_SETUP     = lcd_pkg::T_SETUP,
  parameter int T_EN        = lcd_pkg::T_EN,
  parameter int T_HOLD      = lcd_pkg::T_HOLD,
  parameter int T_EXEC      = lcd_pkg::T_EXEC,
  parameter int T_EXEC_LONG = lcd_pkg::T_EXEC_LONG,
  parameter int CNT_W       = 16
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       cmd_data,
  input  logic       ena_write,
  output logic       done_write,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  lcd_state_t state, state_nxt;
  logic       pending, pend_nxt;
  logic [7:0] data_l, data_nxt;
  logic       cmd_l, cmd_nxt;
  logic       tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic       done_nxt, busy_nxt, rs_nxt, e_nxt;
  logic [3:0] d_nxt;

  // Timer comes out of reset already holding the power-up reload so POWERUP lasts exactly POWERUP_US cycles.
  lcd_tick_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(tick_count(POWERUP_US)))
  ) u_timer (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State, request latch and registered pin drivers; reset drops lcd_e immediately.
  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_POWERUP;
      pending    <= 1'b0;
      data_l     <= 8'h00;
      cmd_l      <= 1'b0;
      done_write <= 1'b0;
      busy       <= 1'b1;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_d      <= 4'h0;
    end else begin
      state      <= state_nxt;
      pending    <= pend_nxt;
      data_l     <= data_nxt;
      cmd_l      <= cmd_nxt;
      done_write <= done_nxt;
      busy       <= busy_nxt;
      lcd_rs     <= rs_nxt;
      lcd_rw     <= 1'b0;
      lcd_e      <= e_nxt;
      lcd_d      <= d_nxt;
    end
  end

  // Next state, timer reload on every state change, and pin values decoded from the state being entered.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pending;
    data_nxt  = data_l;
    cmd_nxt   = cmd_l;
    case (state)
      ST_POWERUP: begin
        if (ena_write && !pending) begin
          pend_nxt = 1'b1;
          data_nxt = data;
          cmd_nxt  = cmd_data;
        end
        if (tmr_zero) begin
          if (pending || ena_write) begin
            state_nxt = ST_HI_SETUP;
            pend_nxt  = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (ena_write) begin
          data_nxt  = data;
          cmd_nxt   = cmd_data;
          state_nxt = ST_HI_SETUP;
        end
      end
      ST_HI_SETUP:  if (tmr_zero) state_nxt = ST_HI_EN;
      ST_HI_EN:     if (tmr_zero) state_nxt = ST_HI_HOLD;
      ST_HI_HOLD:   if (tmr_zero) state_nxt = ST_LO_SETUP;
      ST_LO_SETUP:  if (tmr_zero) state_nxt = ST_LO_EN;
      ST_LO_EN:     if (tmr_zero) state_nxt = ST_LO_HOLD;
      ST_LO_HOLD:   if (tmr_zero) state_nxt = ST_EXEC_WAIT;
      ST_EXEC_WAIT: if (tmr_zero) state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_POWERUP;
    endcase

    tmr_load = (state_nxt != state);
    tmr_val  = '0;
    case (state_nxt)
      ST_POWERUP:               tmr_val = CNT_W'(tick_count(POWERUP_US));
      ST_HI_SETUP, ST_LO_SETUP: tmr_val = CNT_W'(tick_count(T_SETUP));
      ST_HI_EN, ST_LO_EN:       tmr_val = CNT_W'(tick_count(T_EN));
      ST_HI_HOLD, ST_LO_HOLD:   tmr_val = CNT_W'(tick_count(T_HOLD));
      ST_EXEC_WAIT: begin
        // Clear and home (codes 0x00-0x03 as commands) need the long execution time.
        if (!cmd_l && (data_l[7:2] == 6'd0)) tmr_val = CNT_W'(tick_count(T_EXEC_LONG));
        else                                 tmr_val = CNT_W'(tick_count(T_EXEC));
      end
      default:                  tmr_val = '0;
    endcase

    rs_nxt   = lcd_rs;
    d_nxt    = lcd_d;
    e_nxt    = (state_nxt == ST_HI_EN) || (state_nxt == ST_LO_EN);
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
    if (state_nxt == ST_HI_SETUP) begin
      rs_nxt = cmd_nxt;
      d_nxt  = data_nxt[7:4];
    end else if (state_nxt == ST_LO_SETUP) begin
      d_nxt  = data_l[3:0];
    end
  end

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// tb/tb_lcd_nibble_writer.sv - randomized self-checking bench for lcd_nibble_writer
module tb_lcd_nibble_writer;

  localparam int P_US   = 20000;
  localparam int TS     = 1;
  localparam int TE     = 1;
  localparam int TH     = 1;
  localparam int TX     = 40;
  localparam int TX_LNG = 1640;

  logic       clk_1MHz = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       cmd_data;
  logic       ena_write;
  logic       done_write, busy, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_d;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rw_seen = 1'b0;

  int       e_cyc[$];
  bit       e_rs[$];
  bit [3:0] e_nib[$];
  int       done_cyc[$];

  lcd_nibble_writer dut (
    .clk_1MHz   (clk_1MHz),
    .rst_n      (rst_n),
    .data       (data),
    .cmd_data   (cmd_data),
    .ena_write  (ena_write),
    .done_write (done_write),
    .busy       (busy),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_d      (lcd_d)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  always @(posedge clk_1MHz) cyc <= cyc + 1;

  always @(negedge clk_1MHz) begin
    if (lcd_e) begin
      e_cyc.push_back(cyc);
      e_rs.push_back(lcd_rs);
      e_nib.push_back(lcd_d);
    end
    if (done_write) done_cyc.push_back(cyc);
    if (lcd_rw !== 1'b0) rw_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: cycles from acceptance edge to the done pulse, by the byte's classification.
  function automatic int model_latency(input logic [7:0] d, input logic rs);
    int exec_t;
    exec_t = (!rs && d < 8'd4) ? TX_LNG : TX;
    return 2 * (TS + TE + TH) + exec_t + 1;
  endfunction

  task automatic clear_mon();
    e_cyc.delete();
    e_rs.delete();
    e_nib.delete();
    done_cyc.delete();
  endtask

  task automatic pulse(input logic [7:0] d, input logic rs);
    @(negedge clk_1MHz);
    data = d; cmd_data = rs; ena_write = 1'b1;
    @(negedge clk_1MHz);
    ena_write = 1'b0; data = $urandom; cmd_data = $urandom;
  endtask

  // Wait for IDLE, present one request; base is the cycle count just before the acceptance edge.
  task automatic issue(input logic [7:0] d, input logic rs, output int base);
    int t;
    t = 0;
    @(negedge clk_1MHz);
    while (busy && t < 5000) begin @(negedge clk_1MHz); t++; end
    if (t >= 5000) check_eq("idle_timeout", 1, 0);
    clear_mon();
    data = d; cmd_data = rs; ena_write = 1'b1;
    base = cyc;
    @(negedge clk_1MHz);
    ena_write = 1'b0; data = $urandom; cmd_data = $urandom;
    check_eq("busy_after_accept", busy, 1);
  endtask

  task automatic finish_write(input logic [7:0] d, input logic rs, input int base, input int bound);
    int t;
    t = 0;
    while (done_cyc.size() == 0 && t < bound) begin @(negedge clk_1MHz); t++; end
    if (t >= bound) check_eq("done_timeout", 1, 0);
    repeat (50) @(negedge clk_1MHz);
    check_eq("done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check_eq("done_cycle", done_cyc[0] - base, model_latency(d, rs));
    check_eq("e_high_cycles", e_cyc.size(), 2);
    if (e_cyc.size() >= 2) begin
      check_eq("e_hi_cycle", e_cyc[0] - base, TS + 1);
      check_eq("e_lo_cycle", e_cyc[1] - base, TS + TE + TH + TS + 1);
      check_eq("hi_nibble", e_nib[0], d[7:4]);
      check_eq("lo_nibble", e_nib[1], d[3:0]);
      check_eq("rs_hi", e_rs[0], rs);
      check_eq("rs_lo", e_rs[1], rs);
    end
    check_eq("bus_held_d", lcd_d, d[3:0]);
    check_eq("bus_held_rs", lcd_rs, rs);
    check_eq("busy_after_done", busy, 0);
  endtask

  task automatic measure_powerup(input string tag);
    int n;
    n = 0;
    while (n < 25000) begin
      @(negedge clk_1MHz);
      n++;
      if (!busy) break;
    end
    check_eq(tag, n, P_US);
  endtask

  initial begin
    int base;
    logic [7:0] d;
    logic rs;

    rst_n = 1'b0; ena_write = 1'b0; data = 8'h00; cmd_data = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    check_eq("reset_outputs", {done_write, busy, lcd_rs, lcd_rw, lcd_e, lcd_d}, 9'b0_1_0_0_0_0000);
    rst_n = 1'b1;
    measure_powerup("powerup_len");
    check_eq("powerup_no_e", e_cyc.size(), 0);

    issue(8'h41, 1'b1, base);  finish_write(8'h41, 1'b1, base, 3000);
    issue(8'h01, 1'b0, base);  finish_write(8'h01, 1'b0, base, 3000);
    issue(8'h01, 1'b1, base);  finish_write(8'h01, 1'b1, base, 3000);

    issue(8'h06, 1'b0, base);
    repeat (18) @(negedge clk_1MHz);
    pulse(8'h80, 1'b0);
    finish_write(8'h06, 1'b0, base, 3000);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom);
      d  = 8'($urandom);
      if ($urandom_range(3) == 0) d = 8'($urandom_range(3));
      issue(d, rs, base);
      finish_write(d, rs, base, 3000);
    end

    @(negedge clk_1MHz);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_1MHz);
    clear_mon();
    rst_n = 1'b1;
    base = cyc;
    repeat (98) @(negedge clk_1MHz);
    pulse(8'h28, 1'b0);
    repeat (98) @(negedge clk_1MHz);
    pulse(8'h0C, 1'b0);
    finish_write(8'h28, 1'b0, base + P_US - 1, 22000);

    issue(8'h41, 1'b1, base);
    repeat (4) @(negedge clk_1MHz);
    check_eq("e_in_lo_en", lcd_e, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("e_async_drop", lcd_e, 0);
    check_eq("busy_in_reset", busy, 1);
    check_eq("done_in_reset", done_write, 0);
    clear_mon();
    @(negedge clk_1MHz);
    rst_n = 1'b1;
    measure_powerup("powerup_rerun_len");
    check_eq("abort_no_done", done_cyc.size(), 0);
    check_eq("abort_no_e", e_cyc.size(), 0);
    check_eq("rw_always_low", rw_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
